// File: rtl/booth_mult_ctrl_if.sv
// Bundle of request, result and shared-adder signals for the Booth multiply sequencer.
// The master side is the issuing stage plus the cla_adder. The slave side is booth_mult_ctrl.
interface booth_mult_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_c0;
    logic [WIDTH-1:0] add_s;
    logic             add_ovf;
    logic             busy;
    logic             result_rdy;
    logic [WIDTH-1:0] result;
    logic             exception;

    modport master (
        output start, operand_a, operand_b, add_s, add_ovf,
        input  add_x, add_y, add_c0, busy, result_rdy, result, exception
    );

    modport slave (
        input  start, operand_a, operand_b, add_s, add_ovf,
        output add_x, add_y, add_c0, busy, result_rdy, result, exception
    );
endinterface

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth sequencer for a 32-bit signed multiply on one shared external cla_adder.
// Optional early termination is enabled by defining MULT_EARLY_TERM_EN.
module booth_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    booth_mult_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             q_1;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             rdy_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;

    logic [WIDTH-1:0] add_x_c;
    logic [WIDTH-1:0] add_y_c;
    logic             add_c0_c;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic             q_nxt;
    logic             last;
    logic             sgn;

    // The adder only produces 32 bits, so the true 33-bit sign is recovered from the overflow flag.
    assign sgn = bus.add_s[WIDTH-1] ^ bus.add_ovf;

`ifdef MULT_EARLY_TERM_EN
    logic [CNT_W-1:0]         k;
    logic [WIDTH-1:0]         ones;
    logic [WIDTH-1:0]         mask;
    logic                     early;
    logic signed [2*WIDTH-1:0] hilo_s;
    logic signed [2*WIDTH-1:0] hilo_shifted;

    // When the remaining multiplier bits all match q_1, the remaining iterations are pure
    // arithmetic shifts. They collapse into a single shift by k.
    assign k            = CNT_W'(WIDTH) - cnt;
    assign ones         = '1;
    assign mask         = ~(ones << k);
    assign early        = (state == RUN) && (((lo ^ {WIDTH{q_1}}) & mask) == '0);
    assign hilo_s       = {hi, lo};
    assign hilo_shifted = hilo_s >>> k;
`endif

    always_comb begin
        add_x_c  = '0;
        add_y_c  = '0;
        add_c0_c = 1'b0;
        if (state == RUN) begin
            add_x_c = hi;
            case ({lo[0], q_1})
                2'b01:   add_y_c = m;
                2'b10: begin
                    add_y_c  = ~m;
                    add_c0_c = 1'b1;
                end
                default: add_y_c = '0;
            endcase
        end
`ifdef MULT_EARLY_TERM_EN
        if (early) begin
            add_y_c  = '0;
            add_c0_c = 1'b0;
        end
`endif
    end

    always_comb begin
        hi_nxt = {sgn, bus.add_s[WIDTH-1:1]};
        lo_nxt = {bus.add_s[0], lo[WIDTH-1:1]};
        q_nxt  = lo[0];
        last   = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
        if (early) begin
            {hi_nxt, lo_nxt} = hilo_shifted;
            q_nxt            = q_1;
            last             = 1'b1;
        end
`endif
    end

    // The result and exception registers are written only on entry to DONE.
    // They therefore stay valid through IDLE until the next operation finishes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            q_1      <= 1'b0;
            m        <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    rdy_q <= 1'b0;
                    if (bus.start) begin
                        m      <= bus.operand_a;
                        hi     <= '0;
                        lo     <= bus.operand_b;
                        q_1    <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    q_1 <= q_nxt;
                    if (last) begin
                        busy_q   <= 1'b0;
                        rdy_q    <= 1'b1;
                        result_q <= lo_nxt;
                        exc_q    <= (hi_nxt != {WIDTH{lo_nxt[WIDTH-1]}});
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.add_x      = add_x_c;
    assign bus.add_y      = add_y_c;
    assign bus.add_c0     = add_c0_c;
    assign bus.busy       = busy_q;
    assign bus.result_rdy = rdy_q;
    assign bus.result     = result_q;
    assign bus.exception  = exc_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Scoreboard bench for booth_mult_ctrl. A behavioural cla_adder drives the shared adder,
// and each result is compared against a 64-bit reference product.
module tb_booth_mult_ctrl;

    localparam int LAT_EDGES = 32;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          acc;
        int          lat;
    } exp_t;

    logic clock;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [31:0] last_res;
    logic [31:0] sum_tmp;

    booth_mult_ctrl_if #(.WIDTH(32)) bus ();

    booth_mult_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc++;

    // Behavioural stand-in for the shared cla_adder: x + y + c0 with signed overflow.
    always_comb begin
        sum_tmp     = bus.add_x + bus.add_y + {31'b0, bus.add_c0};
        bus.add_s   = sum_tmp;
        bus.add_ovf = (bus.add_x[31] == bus.add_y[31]) && (sum_tmp[31] != bus.add_x[31]);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge. The DUT samples the request on the following posedge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit accepted);
        longint pa;
        longint pb;
        longint p;
        exp_t   e;
        bus.start     = 1'b1;
        bus.operand_a = a;
        bus.operand_b = b;
        if (accepted) begin
            pa    = longint'($signed(a));
            pb    = longint'($signed(b));
            p     = pa * pb;
            e.res = p[31:0];
            e.exc = (p[63:32] != {32{p[31]}});
            e.acc = cyc + 1;
`ifdef MULT_EARLY_TERM_EN
            e.lat = (a == 0 && b == 0) ? 1 : -1;
`else
            e.lat = LAT_EDGES;
`endif
            sb.push_back(e);
            last_res = e.res;
        end
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic waitForRdy();
        int n;
        n = 0;
        while (!bus.result_rdy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.result_rdy) checkOutput("rdy_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clock);
    endtask

    // Pops the scoreboard whenever the DUT pulses result_rdy.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && bus.result_rdy) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("result", 64'(bus.result), 64'(e.res));
                checkOutput("exception", 64'(bus.exception), 64'(e.exc));
                if (e.lat >= 0) checkOutput("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        last_res      = '0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_rdy", 64'(bus.result_rdy), 64'd0);
        checkOutput("rst_result", 64'(bus.result), 64'd0);
        checkOutput("rst_exc", 64'(bus.exception), 64'd0);
        checkOutput("rst_add_x", 64'(bus.add_x), 64'd0);
        checkOutput("rst_add_y", 64'(bus.add_y), 64'd0);
        checkOutput("rst_add_c0", 64'(bus.add_c0), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        applyStimulus(32'd3, 32'd5, 1'b1);
        checkOutput("busy_run", 64'(bus.busy), 64'd1);
        waitDrain();
        applyStimulus(-32'sd7, 32'd6, 1'b1);
        waitDrain();
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitDrain();
        applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b1);
        waitDrain();
        repeat (3) @(negedge clock);
        checkOutput("result_hold", 64'(bus.result), 64'(last_res));

        // Abort an operation partway through with an asynchronous reset.
        applyStimulus(32'd3, 32'd5, 1'b1);
        repeat (8) @(negedge clock);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_result", 64'(bus.result), 64'd0);
        checkOutput("abort_rdy", 64'(bus.result_rdy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);

        // A second request four cycles into a run must be ignored.
        applyStimulus(32'd2, 32'd2, 1'b1);
        repeat (4) @(negedge clock);
        applyStimulus(32'd9, 32'd9, 1'b0);
        waitDrain();

        applyStimulus(32'd0, 32'd0, 1'b1);
        waitDrain();

        // Back-to-back: each new start coincides with the previous result_rdy.
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        waitForRdy();
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
        waitForRdy();
        applyStimulus(32'h8000_0000, 32'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            waitForRdy();
            applyStimulus($urandom, (i % 2 == 0) ? $urandom : $urandom_range(0, 1000), 1'b1);
        end
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
